// File: rtl/spi_fifo_ctrl_v2_pkg.sv
// spi_fifo_ctrl_v2_pkg: shared defaults and status type for the SPI FIFO
package spi_fifo_ctrl_v2_pkg;
  localparam int SPI_FIFO_DEPTH_DEF = 16;
  localparam int SPI_DATA_WIDTH_DEF = 8;
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } spi_fifo_status_t;
endpackage

// File: rtl/spi_fifo_ram.sv
// spi_fifo_ram: simple dual-port storage, sync write / async read, swappable for a macro
module spi_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/spi_fifo_ctrl_v2.sv
// spi_fifo_ctrl_v2: FWFT FIFO with level, thresholds and sticky error bits
module spi_fifo_ctrl_v2
  import spi_fifo_ctrl_v2_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH_DEF,
  parameter int DEPTH = SPI_FIFO_DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  store,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [PTR_W:0]        afull_thr,
  input  logic [PTR_W:0]        aempty_thr,
  input  logic                  err_clr,
  output logic [PTR_W:0]        level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ovf_sticky,
  output logic                  udf_sticky
);
  logic [PTR_W:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic ovf_sticky_q, ovf_sticky_d, udf_sticky_q, udf_sticky_d;
  logic rd_en, wr_en;
  logic [DATA_WIDTH-1:0] ram_rdata;
  spi_fifo_status_t st;
  assign level = w_ptr_q - r_ptr_q;
  always_comb begin
    st = '0;
    st.empty = level == '0;
    st.full = level == (PTR_W+1)'(DEPTH);
    st.almost_full = level >= afull_thr;
    st.almost_empty = level <= aempty_thr;
    st.overflow = !clear & store & st.full & !load;
    st.underflow = !clear & load & st.empty;
    rd_en = !clear & load & !st.empty;
    // a read at full frees the slot the write needs in the same cycle
    wr_en = !clear & store & (!st.full | rd_en);
    w_ptr_d = clear ? '0 : w_ptr_q + (PTR_W+1)'(wr_en);
    r_ptr_d = clear ? '0 : r_ptr_q + (PTR_W+1)'(rd_en);
    ovf_sticky_d = clear ? 1'b0 : st.overflow ? 1'b1 : err_clr ? 1'b0 : ovf_sticky_q;
    udf_sticky_d = clear ? 1'b0 : st.underflow ? 1'b1 : err_clr ? 1'b0 : udf_sticky_q;
  end
  always_ff @(posedge clk) begin
    w_ptr_q <= rst ? '0 : w_ptr_d;
    r_ptr_q <= rst ? '0 : r_ptr_d;
    ovf_sticky_q <= rst ? 1'b0 : ovf_sticky_d;
    udf_sticky_q <= rst ? 1'b0 : udf_sticky_d;
  end
  spi_fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_W(PTR_W)) u_ram (
    .clk(clk),
    .we(wr_en),
    .waddr(w_ptr_q[PTR_W-1:0]),
    .wdata(data_in),
    .raddr(r_ptr_q[PTR_W-1:0]),
    .rdata(ram_rdata)
  );
  assign data_out = st.empty ? '0 : ram_rdata;
  assign full = st.full;
  assign empty = st.empty;
  assign almost_full = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow = st.overflow;
  assign underflow = st.underflow;
  assign ovf_sticky = ovf_sticky_q;
  assign udf_sticky = udf_sticky_q;
endmodule

// File: tb/tb_spi_fifo_ctrl_v2.sv
// tb_spi_fifo_ctrl_v2: directed test of the FIFO at DEPTH=4
module tb_spi_fifo_ctrl_v2;
  logic clk = 1'b0, rst, clear, store, load, err_clr;
  logic [7:0] data_in, data_out;
  logic [2:0] afull_thr, aempty_thr, level;
  logic full, empty, almost_full, almost_empty, overflow, underflow, ovf_sticky, udf_sticky;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  spi_fifo_ctrl_v2 #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .store(store), .data_in(data_in),
    .load(load), .data_out(data_out), .afull_thr(afull_thr), .aempty_thr(aempty_thr),
    .err_clr(err_clr), .level(level), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow),
    .underflow(underflow), .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    store = 0; load = 0; clear = 0; err_clr = 0;
  endtask
  task automatic push(input logic [7:0] d);
    store = 1; data_in = d;
    tick();
    store = 0;
  endtask
  initial begin
    rst = 1; idle(); data_in = 0; afull_thr = 3; aempty_thr = 1;
    tick(); tick();
    chk("rst_level", level, 0); chk("rst_empty", empty, 1); chk("rst_full", full, 0);
    chk("rst_aempty", almost_empty, 1); chk("rst_afull", almost_full, 0);
    chk("rst_dout", data_out, 0); chk("rst_ovfs", ovf_sticky, 0); chk("rst_udfs", udf_sticky, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      store = 1; data_in = 8'hA1 + 8'(i);
      #1 chk("fill_ovf", overflow, 0);
      tick();
      chk("fill_level", level, i + 1);
      chk("fill_afull", almost_full, (i + 1) >= 3);
      chk("fill_full", full, i == 3);
    end
    data_in = 8'hEE;
    #1 chk("ovf_pulse", overflow, 1);
    tick(); store = 0;
    #1 chk("ovf_after", overflow, 0);
    chk("ovf_sticky", ovf_sticky, 1); chk("ovf_level", level, 4); chk("ovf_head", data_out, 8'hA1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_dout", data_out, 8'hA1 + 8'(i));
      load = 1; tick(); load = 0;
    end
    chk("drain_empty", empty, 1); chk("drain_dout0", data_out, 0); chk("drain_aempty", almost_empty, 1);
    load = 1;
    #1 chk("udf_pulse", underflow, 1);
    tick(); load = 0;
    #1 chk("udf_after", underflow, 0);
    chk("udf_sticky", udf_sticky, 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("errclr_ovf", ovf_sticky, 0); chk("errclr_udf", udf_sticky, 0);
    for (int i = 0; i < 4; i++) begin
      push(8'h10 + 8'(i));
      q.push_back(8'h10 + 8'(i));
    end
    chk("full_again", full, 1);
    for (int k = 0; k < 6; k++) begin
      store = 1; load = 1; data_in = 8'h20 + 8'(k);
      #1 chk("sl_ovf", overflow, 0);
      chk("sl_dout", data_out, q[0]);
      tick();
      void'(q.pop_front());
      q.push_back(8'h20 + 8'(k));
      chk("sl_level", level, 4);
    end
    idle();
    while (q.size() > 0) begin
      chk("wrap_dout", data_out, q.pop_front());
      load = 1; tick(); load = 0;
    end
    chk("wrap_empty", empty, 1);
    store = 1; load = 1; data_in = 8'h5C;
    #1 chk("e_sl_udf", underflow, 1); chk("e_sl_ovf", overflow, 0);
    tick(); idle();
    chk("e_sl_level", level, 1); chk("e_sl_dout", data_out, 8'h5C); chk("e_sl_udfs", udf_sticky, 1);
    push(8'h61); push(8'h62);
    chk("pre_clr_level", level, 3);
    clear = 1; store = 1; data_in = 8'h77;
    #1 chk("clr_ovf", overflow, 0);
    tick(); idle();
    chk("clr_level", level, 0); chk("clr_empty", empty, 1); chk("clr_dout", data_out, 0);
    chk("clr_udfs", udf_sticky, 0);
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    store = 1; tick(); store = 0;
    chk("ovf2_sticky", ovf_sticky, 1);
    store = 1; err_clr = 1; tick(); idle();
    chk("errclr_vs_set", ovf_sticky, 1);
    chk("errclr_vs_set_head", data_out, 8'h30);
    err_clr = 1; tick(); err_clr = 0;
    chk("errclr_alone", ovf_sticky, 0);
    afull_thr = 4; aempty_thr = 4;
    #1 chk("thr_afull4", almost_full, 1); chk("thr_aempty4", almost_empty, 1);
    aempty_thr = 3;
    #1 chk("thr_aempty3", almost_empty, 0);
    afull_thr = 0;
    store = 1; data_in = 8'h99; rst = 1;
    tick(); idle(); data_in = 0;
    chk("rst2_level", level, 0); chk("rst2_empty", empty, 1); chk("rst2_full", full, 0);
    chk("rst2_afull", almost_full, 1); chk("rst2_aempty", almost_empty, 1);
    chk("rst2_ovf", overflow, 0); chk("rst2_udf", underflow, 0);
    chk("rst2_ovfs", ovf_sticky, 0); chk("rst2_udfs", udf_sticky, 0); chk("rst2_dout", data_out, 0);
    rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
